// File: rtl/sent_crc_check.sv
// rtl/sent_crc_check.sv - SENT fast-channel CRC4 receive checker, one nibble per clock.
// Optional error counter enabled by SENT_CRC_CHK_ERRCNT_EN.
module sent_crc_check #(
  parameter logic [3:0] CRC_SEED = 4'h5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sent_crc_mode,
  input  logic        chk_req,
  input  logic [2:0]  chk_len,
  input  logic [23:0] chk_data,
  input  logic [3:0]  chk_crc,
  output logic        chk_busy,
  output logic        chk_done,
  output logic        chk_ok,
  output logic        chk_err,
  output logic        chk_len_err,
`ifdef SENT_CRC_CHK_ERRCNT_EN
  input  logic        err_cnt_clr,
  output logic [15:0] err_cnt,
`endif
  output logic [3:0]  chk_calc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    AUG  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        mode_q;
  logic [2:0]  len_q;
  logic [23:0] sreg;
  logic [3:0]  crc_ref;
  logic [3:0]  crc;
  logic [2:0]  cnt;
  logic        len_bad_q;
  logic        len_bad;
  logic        last_nibble;
  logic        match;

  function automatic logic [3:0] crc_tab(input logic [3:0] idx);
    case (idx)
      4'd0:    crc_tab = 4'd0;
      4'd1:    crc_tab = 4'd13;
      4'd2:    crc_tab = 4'd7;
      4'd3:    crc_tab = 4'd10;
      4'd4:    crc_tab = 4'd14;
      4'd5:    crc_tab = 4'd3;
      4'd6:    crc_tab = 4'd9;
      4'd7:    crc_tab = 4'd4;
      4'd8:    crc_tab = 4'd1;
      4'd9:    crc_tab = 4'd12;
      4'd10:   crc_tab = 4'd6;
      4'd11:   crc_tab = 4'd11;
      4'd12:   crc_tab = 4'd15;
      4'd13:   crc_tab = 4'd2;
      4'd14:   crc_tab = 4'd8;
      default: crc_tab = 4'd5;
    endcase
  endfunction

  assign len_bad     = (chk_len == 3'd0) || (chk_len == 3'd7);
  assign last_nibble = (cnt == 3'(len_q - 3'd1));
  assign match       = (crc == crc_ref) && !len_bad_q;
  assign chk_busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (chk_req) state_next = len_bad ? DONE : CALC;
      end
      CALC: begin
        if (last_nibble) state_next = mode_q ? AUG : DONE;
      end
      AUG:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Working registers; everything is captured on accept so inputs may move afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      len_q     <= 3'd0;
      sreg      <= 24'd0;
      crc_ref   <= 4'd0;
      crc       <= 4'd0;
      cnt       <= 3'd0;
      len_bad_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (chk_req) begin
            mode_q    <= sent_crc_mode;
            len_q     <= chk_len;
            sreg      <= chk_data;
            crc_ref   <= chk_crc;
            crc       <= CRC_SEED;
            cnt       <= 3'd0;
            len_bad_q <= len_bad;
          end
        end
        CALC: begin
          crc  <= crc_tab(crc) ^ sreg[23:20];
          sreg <= {sreg[19:0], 4'd0};
          cnt  <= cnt + 3'd1;
        end
        AUG: crc <= crc_tab(crc);
        default: ;
      endcase
    end
  end

  // Result registers update on the edge that ends DONE and hold until the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_done    <= 1'b0;
      chk_ok      <= 1'b0;
      chk_err     <= 1'b0;
      chk_len_err <= 1'b0;
      chk_calc    <= 4'd0;
    end else begin
      chk_done <= (state == DONE);
      if (state == DONE) begin
        chk_ok      <= match;
        chk_err     <= !match;
        chk_len_err <= len_bad_q;
        chk_calc    <= len_bad_q ? 4'd0 : crc;
      end
    end
  end

`ifdef SENT_CRC_CHK_ERRCNT_EN
  logic [15:0] err_cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          err_cnt_r <= 16'd0;
    else if (err_cnt_clr)                             err_cnt_r <= 16'd0;
    else if (chk_done && chk_err && err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'd1;
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_sent_crc_check.sv
// tb/tb_sent_crc_check.sv - scoreboard bench for sent_crc_check.
// Error counter scenario built only with SENT_CRC_CHK_ERRCNT_EN.
module tb_sent_crc_check;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sent_crc_mode = 1'b0;
  logic        chk_req = 1'b0;
  logic [2:0]  chk_len = 3'd0;
  logic [23:0] chk_data = 24'd0;
  logic [3:0]  chk_crc = 4'd0;
  logic        chk_busy, chk_done, chk_ok, chk_err, chk_len_err;
  logic [3:0]  chk_calc;
`ifdef SENT_CRC_CHK_ERRCNT_EN
  logic        err_cnt_clr = 1'b0;
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dones = 0;

  typedef struct {
    int         due;
    logic [3:0] calc;
    logic       ok;
    logic       len_err;
  } exp_t;
  exp_t q[$];
  exp_t it;

  sent_crc_check #(.CRC_SEED(4'h5)) dut (
    .clk(clk),
    .rst(rst),
    .sent_crc_mode(sent_crc_mode),
    .chk_req(chk_req),
    .chk_len(chk_len),
    .chk_data(chk_data),
    .chk_crc(chk_crc),
    .chk_busy(chk_busy),
    .chk_done(chk_done),
    .chk_ok(chk_ok),
    .chk_err(chk_err),
    .chk_len_err(chk_len_err),
`ifdef SENT_CRC_CHK_ERRCNT_EN
    .err_cnt_clr(err_cnt_clr),
    .err_cnt(err_cnt),
`endif
    .chk_calc(chk_calc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [3:0] tab(input logic [3:0] i);
    case (i)
      4'd0: tab = 4'd0;   4'd1: tab = 4'd13;  4'd2: tab = 4'd7;   4'd3: tab = 4'd10;
      4'd4: tab = 4'd14;  4'd5: tab = 4'd3;   4'd6: tab = 4'd9;   4'd7: tab = 4'd4;
      4'd8: tab = 4'd1;   4'd9: tab = 4'd12;  4'd10: tab = 4'd6;  4'd11: tab = 4'd11;
      4'd12: tab = 4'd15; 4'd13: tab = 4'd2;  4'd14: tab = 4'd8;  default: tab = 4'd5;
    endcase
  endfunction

  function automatic logic [3:0] model_crc(input logic mode, input int len, input logic [23:0] data);
    logic [3:0] c = 4'h5;
    for (int i = 0; i < len; i++) c = tab(c) ^ data[23 - 4*i -: 4];
    if (mode) c = tab(c);
    return c;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && chk_done) begin
      dones++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got chk_done=1 at cycle %0d, required none", cyc);
      end else begin
        it = q.pop_front();
        if (cyc !== it.due) begin
          errors++;
          $display("FAIL done_latency: got cycle %0d, required %0d", cyc, it.due);
        end
        checks++;
        if (chk_calc !== it.calc) begin
          errors++;
          $display("FAIL chk_calc: got %h, required %h", chk_calc, it.calc);
        end
        checks++;
        if (chk_ok !== it.ok || chk_err !== !it.ok) begin
          errors++;
          $display("FAIL ok_err: got ok=%b err=%b, required ok=%b err=%b", chk_ok, chk_err, it.ok, !it.ok);
        end
        checks++;
        if (chk_len_err !== it.len_err || chk_busy !== 1'b0) begin
          errors++;
          $display("FAIL len_err_busy: got len_err=%b busy=%b, required len_err=%b busy=0",
                   chk_len_err, chk_busy, it.len_err);
        end
      end
    end
  end

  // Called at a negedge; the following posedge is E0. Returns E0's cycle number.
  task automatic send(input logic mode, input logic [2:0] len, input logic [23:0] data,
                      input logic [3:0] crc, output int e0);
    exp_t e;
    logic bad = (len == 3'd0) || (len == 3'd7);
    e0 = cyc + 1;
    e.len_err = bad;
    e.calc    = bad ? 4'd0 : model_crc(mode, int'(len), data);
    e.ok      = !bad && (e.calc == crc);
    e.due     = e0 + (bad ? 1 : (mode ? int'(len) + 2 : int'(len) + 1));
    q.push_back(e);
    sent_crc_mode = mode;
    chk_len  = len;
    chk_data = data;
    chk_crc  = crc;
    chk_req  = 1'b1;
    @(posedge clk);
    #1;
    chk_req  = 1'b0;
    chk_data = 24'($urandom);
    chk_crc  = 4'($urandom);
    chk_len  = 3'($urandom);
    sent_crc_mode = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: got %0d outstanding results, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({chk_busy, chk_done, chk_ok, chk_err, chk_len_err, chk_calc} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0",
               {chk_busy, chk_done, chk_ok, chk_err, chk_len_err, chk_calc});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_recommended();
    int e0;
    send(1'b1, 3'd6, 24'h000000, 4'h5, e0);
    wait_empty();
    send(1'b1, 3'd3, {12'h000, 12'($urandom)}, 4'h9, e0);
    wait_empty();
    for (int i = 0; i < 4; i++) begin
      logic [2:0] l = 3'($urandom_range(1, 6));
      logic [23:0] d = 24'($urandom);
      logic [3:0] c = model_crc(1'b1, int'(l), d) ^ 4'(i & 1);
      send(1'b1, l, d, c, e0);
      wait_empty();
    end
  endtask

  task automatic test_legacy();
    int e0;
    send(1'b0, 3'd6, 24'h000000, 4'hF, e0);
    wait_empty();
    send(1'b0, 3'd6, 24'h000000, 4'h5, e0);
    wait_empty();
    send(1'b0, 3'd1, 24'hA00000, model_crc(1'b0, 1, 24'hA00000), e0);
    wait_empty();
  endtask

  task automatic test_len_err();
    int e0;
    send(1'b1, 3'd0, 24'h123456, 4'h0, e0);
    wait_empty();
    send(1'b0, 3'd7, 24'h000000, 4'hF, e0);
    wait_empty();
  endtask

  task automatic test_abort();
    int e0;
    int d0;
    send(1'b1, 3'd6, 24'h000000, 4'h5, e0);
    @(negedge clk);
    chk_req = 1'b1; chk_len = 3'd1; sent_crc_mode = 1'b0;
    @(negedge clk);
    chk_req = 1'b0;
    while (cyc < e0 + 7) @(negedge clk);
    d0 = dones;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    q.delete();
    checks++;
    if ({chk_busy, chk_done, chk_ok, chk_err, chk_len_err, chk_calc} !== 9'd0) begin
      errors++;
      $display("FAIL abort_outputs: got %b, required 0",
               {chk_busy, chk_done, chk_ok, chk_err, chk_len_err, chk_calc});
    end
    repeat (10) @(negedge clk);
    checks++;
    if (dones !== d0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses, required 0", dones - d0);
    end
    send(1'b0, 3'd2, 24'h5A0000, model_crc(1'b0, 2, 24'h5A0000), e0);
    wait_empty();
  endtask

  task automatic test_back_to_back();
    int e0;
    int n;
    send(1'b0, 3'd4, 24'h123400, model_crc(1'b0, 4, 24'h123400), e0);
    n = 0;
    while (!chk_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!chk_done) begin
      errors++;
      $display("FAIL b2b_first_done: got chk_done=0, required 1");
    end
    send(1'b1, 3'd5, 24'hFEDCB0, 4'h0, e0);
    wait_empty();
  endtask

`ifdef SENT_CRC_CHK_ERRCNT_EN
  task automatic test_err_cnt();
    int e0;
    int n;
    err_cnt_clr = 1'b1;
    @(negedge clk);
    err_cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 3'd6, 24'h000000, 4'h0, e0);
      wait_empty();
    end
    checks++;
    if (err_cnt !== 16'd3) begin
      errors++;
      $display("FAIL err_cnt_three: got %0d, required 3", err_cnt);
    end
    send(1'b0, 3'd6, 24'h000000, 4'h1, e0);
    n = 0;
    while (!chk_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    err_cnt_clr = 1'b1;
    @(negedge clk);
    err_cnt_clr = 1'b0;
    wait_empty();
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL err_cnt_clear: got %0d, required 0", err_cnt);
    end
    force dut.err_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.err_cnt_r;
    send(1'b0, 3'd6, 24'h000000, 4'h2, e0);
    wait_empty();
    checks++;
    if (err_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL err_cnt_saturate: got %h, required FFFF", err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_recommended();
    test_legacy();
    test_len_err();
    test_abort();
    test_back_to_back();
`ifdef SENT_CRC_CHK_ERRCNT_EN
    test_err_cnt();
`endif
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
